// File: rtl/spram32_arb.sv
// Two-requester arbiter in front of a 32K x 32 single-port memory.
// Round-robin between requesters, bounded lock for read-modify-write,
// and a registered read-valid per requester.
module spram32_arb #(
  parameter int unsigned ASZ      = 15,
  parameter int unsigned DSZ      = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic           we0,
  input  logic           we1,
  input  logic           lock0,
  input  logic           lock1,
  input  logic [ASZ-1:0] ai0,
  input  logic [ASZ-1:0] ai1,
  input  logic [3:0]     bmsk0,
  input  logic [3:0]     bmsk1,
  input  logic [DSZ-1:0] vi0,
  input  logic [DSZ-1:0] vi1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           rv0,
  output logic           rv1,
  output logic [DSZ-1:0] vo0,
  output logic [DSZ-1:0] vo1,
  output logic [ASZ-1:0] mem_ai,
  output logic           mem_we,
  output logic [3:0]     mem_bmsk,
  output logic [DSZ-1:0] mem_vi,
  input  logic [DSZ-1:0] mem_vo
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]   cnt_base;
  logic            rv0_q, rv1_q;

  // Grant decision: locked owner first, otherwise round-robin on contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == StOwn0 && req0) begin
        gnt0 = 1'b1;
      end else if (state_q == StOwn1 && req1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Next state, lock counter and round-robin pointer.
  always_comb begin
    state_d    = StIdle;
    lock_cnt_d = '0;
    last_d     = last_q;
    // A grant that is not a continuation of the current lock starts a fresh run.
    cnt_base   = '0;
    if ((gnt0 && state_q == StOwn0) || (gnt1 && state_q == StOwn1)) cnt_base = lock_cnt_q;
    if (gnt0) begin
      last_d = 1'b0;
      if (lock0 && cnt_base < CW'(MAX_LOCK - 1)) begin
        state_d    = StOwn0;
        lock_cnt_d = cnt_base + 1'b1;
      end
    end else if (gnt1) begin
      last_d = 1'b1;
      if (lock1 && cnt_base < CW'(MAX_LOCK - 1)) begin
        state_d    = StOwn1;
        lock_cnt_d = cnt_base + 1'b1;
      end
    end
  end

  // State registers; reset leaves requester 0 winning the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Memory command mux from the granted requester; all zero when idle.
  always_comb begin
    mem_ai   = '0;
    mem_we   = 1'b0;
    mem_bmsk = '0;
    mem_vi   = '0;
    if (gnt0) begin
      mem_ai   = ai0;
      mem_we   = we0;
      mem_bmsk = bmsk0;
      mem_vi   = vi0;
    end else if (gnt1) begin
      mem_ai   = ai1;
      mem_we   = we1;
      mem_bmsk = bmsk1;
      mem_vi   = vi1;
    end
  end

  // Read-valid tracks the one-cycle memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= gnt0 & ~we0;
      rv1_q <= gnt1 & ~we1;
    end
  end

  assign rv0 = rv0_q;
  assign rv1 = rv1_q;
  assign vo0 = mem_vo;
  assign vo1 = mem_vo;

endmodule
